// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: payload/control layouts and pack helpers so every
// stage builds the inter-stage register contents the same way.
package pipe_pkg;

    localparam int PIPE_DATA_W = 128;
    localparam int PIPE_CTRL_W = 8;

    // Control-field widths of each stage boundary
    localparam int IF_ID_CTRL_W  = 1;
    localparam int ID_EX_CTRL_W  = 8;
    localparam int EX_MEM_CTRL_W = 3;
    localparam int MEM_WB_CTRL_W = 2;

    localparam int REG_ID_W = 4;
    localparam int WORD_W   = 32;
    localparam int IMM_W    = 24;

    localparam int ID_EX_SRC_LSB  = 0;
    localparam int ID_EX_DEST_LSB = ID_EX_SRC_LSB + REG_ID_W;
    localparam int ID_EX_IMM_LSB  = ID_EX_DEST_LSB + REG_ID_W;
    localparam int ID_EX_VAL2_LSB = ID_EX_IMM_LSB + IMM_W;
    localparam int ID_EX_VAL1_LSB = ID_EX_VAL2_LSB + WORD_W;
    localparam int ID_EX_PC_LSB   = ID_EX_VAL1_LSB + WORD_W;

    localparam int CTRL_WB_EN_BIT    = 0;
    localparam int CTRL_MEM_R_EN_BIT = 1;
    localparam int CTRL_MEM_W_EN_BIT = 2;
    localparam int CTRL_B_BIT        = 3;
    localparam int CTRL_S_BIT        = 4;
    localparam int CTRL_EXE_CMD_LSB  = 5;
    localparam int EXE_CMD_W         = 3;

    // Field order matches the *_LSB offsets above (pc in the MSBs)
    typedef struct packed {
        logic [WORD_W-1:0]   pc;
        logic [WORD_W-1:0]   val1;
        logic [WORD_W-1:0]   val2;
        logic [IMM_W-1:0]    imm;
        logic [REG_ID_W-1:0] dest;
        logic [REG_ID_W-1:0] src;
    } id_ex_payload_t;

    typedef struct packed {
        logic [EXE_CMD_W-1:0] exe_cmd;
        logic                 s;
        logic                 b;
        logic                 mem_w_en;
        logic                 mem_r_en;
        logic                 wb_en;
    } id_ex_ctrl_t;

    function automatic logic [PIPE_DATA_W-1:0] pack_id_ex_data(input id_ex_payload_t p);
        return p;
    endfunction

    function automatic id_ex_payload_t unpack_id_ex_data(input logic [PIPE_DATA_W-1:0] d);
        return id_ex_payload_t'(d);
    endfunction

    function automatic logic [ID_EX_CTRL_W-1:0] pack_id_ex_ctrl(input id_ex_ctrl_t c);
        return c;
    endfunction

    function automatic id_ex_ctrl_t unpack_id_ex_ctrl(input logic [ID_EX_CTRL_W-1:0] c);
        return id_ex_ctrl_t'(c);
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline slot: valid flag, control field and payload with load and clear.
// Control is zeroed whenever the slot goes invalid so downstream never sees stale control.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W   = PIPE_DATA_W,
    parameter int CTRL_W   = PIPE_CTRL_W,
    parameter bit CLR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              d_valid,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    // An invalid load keeps the old payload to avoid needless toggling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_ctrl  <= '0;
            q_data  <= '0;
        end else if (clear) begin
            q_valid <= 1'b0;
            q_ctrl  <= '0;
            if (CLR_DATA) begin
                q_data <= '0;
            end
        end else if (load) begin
            q_valid <= d_valid;
            q_ctrl  <= d_valid ? d_ctrl : '0;
            if (d_valid) begin
                q_data <= d_data;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional skid
// entry, and flush > freeze > bubble control priority.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W   = PIPE_DATA_W,
    parameter int CTRL_W   = PIPE_CTRL_W,
    parameter bit SKID     = 1'b1,
    parameter bit CLR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              freeze,
    input  logic              bubble,
    output logic [1:0]        occupancy,
    output logic [15:0]       bubble_cnt
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic              main_load;
    logic              main_d_valid;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_d_data;
    logic              skid_load;
    logic              skid_d_valid;
    logic              bubble_slot;
    logic              in_fire;
    logic              out_fire;

    // With a skid entry, in_ready comes straight off the skid valid flop
    always_comb begin
        if (SKID) begin
            in_ready = !skid_valid && !freeze && !bubble;
        end else begin
            in_ready = (!main_valid || out_ready) && !freeze && !bubble;
        end
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_valid && out_ready;

    always_comb begin
        main_load    = 1'b0;
        main_d_valid = 1'b0;
        main_d_ctrl  = in_ctrl;
        main_d_data  = in_data;
        skid_load    = 1'b0;
        skid_d_valid = 1'b0;
        bubble_slot  = 1'b0;
        if (!flush && !freeze) begin
            if (out_fire || !main_valid) begin
                main_load = 1'b1;
                if (skid_valid) begin
                    main_d_valid = 1'b1;
                    main_d_ctrl  = skid_ctrl;
                    main_d_data  = skid_data;
                    skid_load    = 1'b1;
                    skid_d_valid = in_fire && !bubble;
                end else if (bubble) begin
                    bubble_slot = 1'b1;
                end else begin
                    main_d_valid = in_fire;
                end
            end else if (in_fire && !bubble) begin
                skid_load    = 1'b1;
                skid_d_valid = 1'b1;
            end
        end
    end

    pipe_entry_reg #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .CLR_DATA(CLR_DATA)
    ) main_q (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .clear  (flush),
        .d_valid(main_d_valid),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .q_valid(main_valid),
        .q_ctrl (main_ctrl),
        .q_data (main_data)
    );

    pipe_entry_reg #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .CLR_DATA(CLR_DATA)
    ) skid_q (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load && SKID),
        .clear  (flush),
        .d_valid(skid_d_valid),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .q_valid(skid_valid),
        .q_ctrl (skid_ctrl),
        .q_data (skid_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (bubble_slot && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign occupancy = 2'(main_valid) + 2'(skid_valid);

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, generalised inter-stage pipeline register that replaces per-field hand-instantiated register banks between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one packed payload plus a separately clearable control field.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, and flush, freeze and bubble-insert controls with fixed priority.
- Sits between any two pipeline stages; the hazard unit drives freeze and bubble, the branch unit drives flush.

Parameters:
- DATA_W, 128, width of the payload (PC, operands, immediates, dest/src ids), packed by the instantiating stage.
- CTRL_W, 8, width of the control field (WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD …); forced to 0 on flush or bubble.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CLR_DATA, 1, 1 = flush also zeroes the payload; 0 = payload is left unchanged on flush (power saving).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bits.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  registered payload.
- out_ctrl  out  CTRL_W  registered control; 0 whenever out_valid = 0.
- flush  in  1  kill all held entries (taken branch).
- freeze  in  1  hold all state (e.g. memory stall).
- bubble  in  1  refuse input and insert an invalid slot (load-use hazard).
- occupancy  out  2  number of held entries, 0..2.
- bubble_cnt  out  16  saturating count of cycles in which a bubble was inserted.

Behaviour:
- Reset (asynchronous, immediate): out_valid = 0, out_ctrl = 0, out_data = 0, skid entry empty and zeroed, occupancy = 0, bubble_cnt = 0. in_ready = 1 after reset when SKID=1.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Priority per cycle: rst > flush > freeze > bubble > normal.
- flush:
  - Next edge: main and skid entries invalid, their ctrl = 0; data = 0 only if CLR_DATA = 1.
  - The input in the same cycle is discarded; in_ready is still driven but no entry is stored.
  - out_fire in the same cycle is still valid for the consumer.
- freeze (without flush):
  - in_ready = 0; all registers hold.
  - out_valid, out_data and out_ctrl are held stable.
  - Downstream must not treat out_ready as consuming; the internal state ignores out_ready.
- bubble (no flush, no freeze):
  - in_ready = 0.
  - If out_fire or main is empty: main becomes invalid with ctrl = 0, unless the skid is full, in which case the skid moves to main.
  - bubble_cnt increments only when an invalid slot is actually created; it saturates at 0xFFFF.
- Normal operation, SKID=1:
  - in_ready is a registered signal equal to "skid empty".
  - If main is empty or out_fire: main loads skid if the skid is full, else loads input on in_fire, else becomes invalid.
  - If main is valid, there is no out_fire, and in_fire: the input goes to the skid.
  - If the skid moves to main while in_fire: the input goes to the skid.
  - Zero-bubble throughput, one entry per cycle; latency in→out is 1 cycle.
- Normal operation, SKID=0:
  - in_ready = ~out_valid | out_ready (combinational, gated with ~freeze & ~bubble).
  - The skid entry is never used; occupancy is at most 1.
- Invariants:
  - The skid is never full while main is empty.
  - occupancy equals the number of held valid entries (0..2).
  - No entry is lost or duplicated absent a flush.
  - Payload order is FIFO.
- Reset mid-transfer: all held entries are dropped immediately; no partial output.

Decomposition:
- Shared package pipe_pkg holds:
  - Field-offset localparams for each stage payload (ID_EX_PC_LSB …).
  - Per-stage CTRL_W constants.
  - Helper pack/unpack functions, so stages pack in_data/in_ctrl identically.
- One sub-module, pipe_entry_reg: a valid + ctrl + data register with load and clear, instantiated twice (main, skid).

Test Plan:
- Streaming: SKID=1, in_valid = 1 for 10 cycles with data 1..10, out_ready = 1 → out_data = 1..10 on consecutive cycles, 1-cycle latency, in_ready constantly 1.
- Backpressure: stream data 0xA, 0xB, 0xC; drop out_ready for 2 cycles → occupancy goes to 2, in_ready = 0, out_data holds 0xA; release → 0xA, 0xB, 0xC delivered in order with none lost.
- Flush: occupancy = 2 with ctrl 0x3F; assert flush together with in_valid (data 0x55) → next cycle out_valid = 0, out_ctrl = 0, occupancy = 0, and 0x55 never appears.
- Freeze vs bubble: assert freeze and bubble together while holding data 0x7 → state frozen, bubble_cnt unchanged. Then bubble alone with out_ready = 1 → one invalid cycle, bubble_cnt = 1, the next input accepted afterwards.
- Async reset: assert rst mid-cycle while occupancy = 2 → outputs go to 0 immediately, before the clock edge; after release, first input 0x9 appears after 1 cycle.
- SKID=0 build: out_ready = 0 with out_valid = 1 → in_ready = 0 in the same cycle; out_ready = 1 → in_ready = 1 combinationally; occupancy never exceeds 1.
